// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the RV32I MEM stage: access-size encodings, FSM states,
// the MEM/WB boundary record and the byte-lane / extension helpers.
// Pure declarations, no logic of its own.
package mem_stage_pkg;

    localparam int DATA_W = 32;

    // funct3 access-size encodings
    localparam logic [2:0] MEM_SZ_B  = 3'b000;
    localparam logic [2:0] MEM_SZ_H  = 3'b001;
    localparam logic [2:0] MEM_SZ_W  = 3'b010;
    localparam logic [2:0] MEM_SZ_BU = 3'b100;
    localparam logic [2:0] MEM_SZ_HU = 3'b101;

    // access width class, independent of signedness
    localparam logic [1:0] KIND_B = 2'd0;
    localparam logic [1:0] KIND_H = 2'd1;
    localparam logic [1:0] KIND_W = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] ula_result;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_to_reg;
        logic              misalign;
    } memwb_t;

    // Undefined encodings fall into the word class.
    function automatic logic [1:0] size_kind(input logic [2:0] size);
        case (size)
            MEM_SZ_B, MEM_SZ_BU: size_kind = KIND_B;
            MEM_SZ_H, MEM_SZ_HU: size_kind = KIND_H;
            default:             size_kind = KIND_W;
        endcase
    endfunction

    // Natural alignment: halfwords drop addr[0], words drop addr[1:0].
    function automatic logic [1:0] align_lane(input logic [1:0] kind, input logic [1:0] lane);
        case (kind)
            KIND_B:  align_lane = lane;
            KIND_H:  align_lane = {lane[1], 1'b0};
            default: align_lane = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] kind, input logic [1:0] lane);
        case (kind)
            KIND_B:  byte_en = 4'b0001 << lane;
            KIND_H:  byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // rs2 replicated so every enabled lane already carries the right bits.
    function automatic logic [DATA_W-1:0] store_data(input logic [1:0] kind, input logic [DATA_W-1:0] d);
        case (kind)
            KIND_B:  store_data = {4{d[7:0]}};
            KIND_H:  store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] size, input logic [1:0] lane,
                                                   input logic [DATA_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            MEM_SZ_B:  load_ext = {{24{b[7]}}, b};
            MEM_SZ_BU: load_ext = {24'b0, b};
            MEM_SZ_H:  load_ext = {{16{h[15]}}, h};
            MEM_SZ_HU: load_ext = {16'b0, h};
            default:   load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-addressable single-port data RAM: per-lane write enables, registered read.
// Latency: write and read both take effect at the enabled clock edge; rdata holds until the next access.
// Backpressure: none; the caller sequences accesses. Contents are never reset.
// Ports: clk; en (access strobe); we + be[3:0] (lane writes); addr (word index); wdata; rdata.
module data_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-during-write returns the old word; no caller needs the new one.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage_pl.sv
// MEM stage of the 5-stage RV32I pipeline: data RAM access, load extension, branch resolve, MEM/WB register.
// Latency: non-memory ops 1 cycle; loads/stores MEM_LATENCY+1 cycles (stall_o high for MEM_LATENCY of them).
// Backpressure: stall_o tells the hazard unit to hold EX/MEM; inputs are consumed on valid_in & !stall_o.
// Ports: clk/rst (async high); EX/MEM bundle in (valid_in, alu_result, add_sum, rs2, controls, mem_size, rd);
//   branch_taken/branch_target to IF; wb_valid, read_data, ula_result, rd_out, reg_write_out,
//   mem_to_reg_out, misalign_o to WB. Optional macro MEM_MISALIGN_TRAP_EN flags misaligned H/W accesses.
module mem_stage_pl
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] alu_result,
    input  logic            flag_zero,
    input  logic [XLEN-1:0] add_sum,
    input  logic [XLEN-1:0] read_data_2_in,
    input  logic            mem_read_control,
    input  logic            mem_write_control,
    input  logic            branch_control,
    input  logic [2:0]      mem_size,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    input  logic            mem_to_reg_in,
    output logic            stall_o,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            wb_valid,
    output logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] ula_result,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            mem_to_reg_out,
    output logic            misalign_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    memwb_t            memwb_q, memwb_d;

    logic              mem_op, is_load, consume, ram_access, ram_we, misalign;
    logic [1:0]        kind, lane;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr_hi;

    // Bits above the RAM index are ignored, so addresses wrap modulo DEPTH*4.
    assign unused_addr_hi = ^alu_result[XLEN-1:AW+2];

    assign mem_op  = valid_in & (mem_read_control | mem_write_control);
    assign is_load = mem_read_control & ~mem_write_control;   // store wins when both are set
    assign stall_o = mem_op & (state_q != DONE);
    assign consume = valid_in & ~stall_o;

    assign kind = size_kind(mem_size);
    assign lane = align_lane(kind, alu_result[1:0]);
    // Only the trap build reports it; otherwise the forced alignment above simply applies.
    assign misalign = TRAP_EN & (lane != alu_result[1:0]);

    assign ram_we = ram_access & mem_write_control & ~misalign;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (MEM_LATENCY == 1) begin
                        ram_access = 1'b1;
                        state_d    = DONE;
                    end else begin
                        cnt_d   = CNT_W'(MEM_LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Walk on even if valid_in dropped, but only touch the RAM for a live op.
                if (cnt_q == '0) begin
                    ram_access = mem_op;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        memwb_d          = memwb_q;
        memwb_d.valid    = 1'b0;
        memwb_d.misalign = 1'b0;
        if (consume) begin
            memwb_d.valid      = 1'b1;
            memwb_d.ula_result = alu_result;
            memwb_d.rd         = rd_in;
            memwb_d.reg_write  = reg_write_in;
            memwb_d.mem_to_reg = mem_to_reg_in;
            memwb_d.misalign   = mem_op & misalign;
            memwb_d.read_data  = (is_load & ~misalign) ? load_ext(mem_size, lane, ram_rdata) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            memwb_q <= memwb_d;
        end
    end

    data_ram #(.DEPTH(DEPTH)) u_data_ram (
        .clk   (clk),
        .en    (ram_access),
        .we    (ram_we),
        .be    (byte_en(kind, lane)),
        .addr  (alu_result[AW+1:2]),
        .wdata (store_data(kind, read_data_2_in)),
        .rdata (ram_rdata)
    );

    // Branch resolution is not held back by a memory stall.
    assign branch_taken  = valid_in & branch_control & flag_zero;
    assign branch_target = add_sum;

    assign wb_valid       = memwb_q.valid;
    assign read_data      = memwb_q.read_data;
    assign ula_result     = memwb_q.ula_result;
    assign rd_out         = memwb_q.rd;
    assign reg_write_out  = memwb_q.reg_write;
    assign mem_to_reg_out = memwb_q.mem_to_reg;
    assign misalign_o     = memwb_q.misalign;

endmodule

// File: doc/mem_stage_pl.md
Name: mem_stage_pl

Overview:
Parametrised MEM stage of the 5-stage RV32I pipeline. It holds a byte-addressable data RAM with byte, halfword and word loads and stores, plus sign/zero extension. It supports a configurable multi-cycle memory latency, signalling a stall back to the hazard unit. It resolves branches toward IF and registers the MEM/WB pipeline boundary.

Parameters:
DEPTH, 1024, data RAM depth in 32-bit words (power of 2); AW = $clog2(DEPTH)
MEM_LATENCY, 1, RAM access cycles (>=1); a memory op occupies MEM_LATENCY+1 cycles
XLEN, 32, datapath width (fixed at 32; parameter only for package consistency)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_in  in  1  EX/MEM holds a valid instruction
alu_result  in  32  effective address / ALU result
flag_zero  in  1  ALU zero flag
add_sum  in  32  branch target
read_data_2_in  in  32  store data (rs2)
mem_read_control  in  1  load
mem_write_control  in  1  store
branch_control  in  1  branch instruction
mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_in  in  5  destination register
reg_write_in  in  1  WB write enable
mem_to_reg_in  in  1  WB mux select
stall_o  out  1  input not consumed; upstream must hold inputs
branch_taken  out  1  combinational PCSrc
branch_target  out  32  = add_sum
wb_valid  out  1  MEM/WB valid
read_data  out  32  extended load data
ula_result  out  32  registered alu_result
rd_out  out  5  registered rd_in
reg_write_out  out  1  registered
mem_to_reg_out  out  1  registered
misalign_o  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): FSM to IDLE, wait counter 0, all registered outputs 0. RAM contents are not reset.
- Input consumed on an edge where valid_in & !stall_o. stall_o = valid_in & (mem_read_control | mem_write_control) & (state != DONE).
- Non-memory op: 1 cycle. MEM/WB loaded at the next edge; wb_valid=1; read_data=0.
- Memory op FSM:
  - IDLE: if MEM_LATENCY==1, the RAM access happens at this edge, then go to DONE. Otherwise load cnt=MEM_LATENCY-2 and go to WAIT.
  - WAIT: if cnt==0, the RAM access happens at this edge, then go to DONE; otherwise decrement cnt.
  - DONE: stall_o=0. The edge loads MEM/WB with extended RAM data, sets wb_valid=1, and returns to IDLE.
- Store commits at the RAM-access edge. Load data is registered in the RAM at the same edge.
- If valid_in drops mid-access: the FSM still walks to IDLE, MEM/WB is not loaded (wb_valid=0), and a store already committed stays committed.
- Both mem_read_control and mem_write_control high: store wins; read_data=0.
- Address decode:
  - Word index = alu_result[AW+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = alu_result[1:0]; halfword lane = alu_result[1].
- Store byte-enables: B = one lane, H = two lanes, W = all four. Store data is rs2 replicated across lanes.
- Load extension:
  - B and H sign-extend; BU and HU zero-extend.
  - Undefined mem_size values are treated as W.
- branch_taken = valid_in & branch_control & flag_zero. It is combinational and is not gated by stall.
- wb_valid is a one-cycle pulse per consumed instruction.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - No RAM write occurs.
  - read_data=0.
  - misalign_o=1 alongside wb_valid.
  - Normal latency still applies.
- Undefined: misalign_o is tied 0 and low address bits are forced aligned (H ignores addr[0]; W ignores addr[1:0]).

Decomposition:
- Package mem_stage_pkg holds:
  - the mem_size encodings as localparams;
  - the state_t enum {IDLE, WAIT, DONE};
  - the MEM/WB struct.
- Sub-module data_ram: a synchronous single-port RAM with 4-bit byte enables and registered read, parametrised by DEPTH.

Test Plan:
1. LAT=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> each op has stall_o=1 for 1 cycle; LW gives read_data=0xDEADBEEF, wb_valid pulse on the 2nd edge.
2. After test 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD.
3. SB rs2=0x12345655 @0x11, then LW @0x10 -> 0xDEAD55EF. An address of 0x10+DEPTH*4 aliases to the same word.
4. LAT=3: LW -> stall_o high 3 cycles, wb_valid on the 4th edge. An ALU op directly following gets wb_valid one cycle later with read_data=0.
5. branch_control=1, flag_zero=1, add_sum=0x40 -> branch_taken=1, branch_target=0x40. With flag_zero=0 -> branch_taken=0.
6. rst pulsed while in WAIT -> all outputs 0 immediately, FSM in IDLE, RAM word intact. With MEM_MISALIGN_TRAP_EN: SW @0x12 -> misalign_o=1 and memory unchanged.
